// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings, state constants and sign helpers for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [31:0] mag32(input logic neg, input logic [31:0] v);
    mag32 = neg ? (~v + 32'd1) : v;
  endfunction

  // Quotient/product take the sign of a^b, remainder takes the sign of the dividend.
  function automatic logic [63:0] sign_fix(input logic is_div, input logic sa,
                                           input logic sb, input logic [63:0] raw);
    logic [31:0] q;
    logic [31:0] r;
    if (is_div) begin
      q = (sa ^ sb) ? (~raw[31:0] + 32'd1) : raw[31:0];
      r = sa ? (~raw[63:32] + 32'd1) : raw[63:32];
      sign_fix = {r, q};
    end else begin
      sign_fix = (sa ^ sb) ? (~raw + 64'd1) : raw;
    end
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// One radix-2 step: restoring divide on {rem, quo} or shift-add multiply on {hi, multiplier}.
module div_iter (
  input  logic [63:0] i_acc,
  input  logic        i_is_div,
  input  logic [31:0] i_opnd,
  output logic [63:0] o_acc
);

  logic [32:0] w_diff;
  logic [32:0] w_sum;

  // Partial remainder is 33 bits after the shift; the carry of the add re-enters at the top.
  always_comb begin
    w_diff = i_acc[63:31] - {1'b0, i_opnd};
    w_sum  = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};
    o_acc  = i_acc;
    if (i_is_div) begin
      if (!w_diff[32]) begin
        o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
      end else begin
        o_acc = {i_acc[62:0], 1'b0};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[31:1]};
      end else begin
        o_acc = {1'b0, i_acc[63:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO pair with an EX stall request.
// Define MULT_ONECYCLE_EN to complete multiplies through a single registered 32x32 product.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  output logic        o_stall_req,
  output logic        o_done,
  output logic        o_hilo_we,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out
);

  logic [1:0]       r_state;
  logic             r_is_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [31:0]      r_opnd;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_is_div;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_step;
  logic        w_accept;

  // Operand decode: magnitudes and sign flags for the signed ops, raw values otherwise.
  always_comb begin
    w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    w_sign_a = ((i_op == OP_MULT) || (i_op == OP_DIV)) && i_src_a[31];
    w_sign_b = ((i_op == OP_MULT) || (i_op == OP_DIV)) && i_src_b[31];
    w_mag_a  = mag32(w_sign_a, i_src_a);
    w_mag_b  = mag32(w_sign_b, i_src_b);
    w_accept = (r_state == S_IDLE) && i_start && !i_flush;
  end

  div_iter u_div_iter (
    .i_acc    (r_acc),
    .i_is_div (r_is_div),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  // Sequencer: accept in IDLE, iterate in RUN, one-cycle HI/LO write in DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= w_is_div;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_cnt    <= '0;
            if (w_is_div && (i_src_b == 32'd0)) begin
              r_hi    <= i_src_a;
              r_lo    <= 32'hFFFF_FFFF;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
`ifdef MULT_ONECYCLE_EN
            else if (!w_is_div) begin
              {r_hi, r_lo} <= sign_fix(1'b0, w_sign_a, w_sign_b,
                                       {32'd0, w_mag_a} * {32'd0, w_mag_b});
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
`endif
            else begin
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
              r_acc   <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
              {r_hi, r_lo} <= sign_fix(r_is_div, r_sign_a, r_sign_b, w_step);
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall_req = w_accept || (r_state == S_RUN);
  assign o_done      = r_done;
  assign o_hilo_we   = r_done;
  assign o_hi_out    = r_hi;
  assign o_lo_out    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized self-checking bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_hilo = 64'd0;

`ifdef MULT_ONECYCLE_EN
  localparam bit ONECYC = 1'b1;
`else
  localparam bit ONECYC = 1'b0;
`endif

  hilo_muldiv_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .i_flush     (flush),
    .o_stall_req (stall_req),
    .o_done      (done),
    .o_hilo_we   (hilo_we),
    .o_hi_out    (hi_out),
    .o_lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed ops via 64-bit signed arithmetic (truncating division), returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 1;
    if (!o[1] && ONECYC) return 1;
    return 33;
  endfunction

  // Issue one instruction at a negedge and check every cycle until one past its write.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] exp;
    lat = ref_latency(o, b);
    exp = ref_result(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check_eq("stall_c0", {63'd0, stall_req}, 64'd1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq($sformatf("stall_c%0d", c), {63'd0, stall_req}, {63'd0, (c < lat)});
      check_eq($sformatf("done_c%0d", c), {63'd0, done}, {63'd0, (c == lat)});
      check_eq("hilo_we", {63'd0, hilo_we}, {63'd0, (c == lat)});
      if (c == lat) begin
        check_eq($sformatf("hilo op%0d %0h/%0h", o, a, b), {hi_out, lo_out}, exp);
      end
    end
    last_hilo = exp;
    @(negedge clk);
    #1;
    check_eq("done_after", {63'd0, done}, 64'd0);
    check_eq("idle_stall", {63'd0, stall_req}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_outs", {hi_out, lo_out}, 64'd0);
    check_eq("rst_done", {62'd0, done, hilo_we}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_req}, 64'd0);
    rst = 1'b0;

    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // start with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd5;
    #1;
    check_eq("start_flush_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check_eq("start_flush_idle", {63'd0, stall_req}, 64'd0);

    // flush mid-RUN: cycle 11 is IDLE, no write, outputs hold
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (c == 10);
    end
    flush = 1'b0;
    #1;
    check_eq("flush_stall", {63'd0, stall_req}, 64'd0);
    for (int c = 12; c <= 36; c++) begin
      @(negedge clk);
      #1;
      check_eq("flush_nowrite", {63'd0, hilo_we}, 64'd0);
    end
    check_eq("flush_hold", {hi_out, lo_out}, last_hilo);
    run_op(2'b11, 32'd9, 32'd3);

    // async reset mid-RUN
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd77; src_b = 32'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_outs", {hi_out, lo_out}, 64'd0);
    check_eq("midrst_done", {62'd0, done, hilo_we}, 64'd0);
    check_eq("midrst_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_hilo = 64'd0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
